chroma_upsampler: RTL and testbench

CHROMA_UPSAMPLER -- requirements
Module: chroma_upsampler

---
 rtl/chroma_upsampler.sv | 179 +++++++++++++++++
 tb/tb_chroma_upsampler.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/chroma_upsampler.sv
// chroma_upsampler
//   Horizontal 2x chroma upsampler for one U or V plane in raster order.
//   Every accepted chroma sample U[k] yields a pixel pair: out_even = U[k]
//   and out_odd = a 6-tap half-sample interpolation between U[k] and U[k+1].
//   Samples outside the line are clamped to the first/last sample.
//
//   Build option: define UPSAMPLE_SAT_EN to clamp out_odd to 0..255;
//   without it out_odd is the low byte of the filter result (wraps).
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   in_data holds a chroma sample
//   in_ready   sample accepted this cycle
//   in_data    unsigned 8-bit chroma sample
//   out_valid  out_even/out_odd pair is valid
//   out_ready  downstream consumes the pair
//   out_even   chroma for pixel 2k
//   out_odd    interpolated chroma for pixel 2k+1
//   out_last   pair k = SAMPLES_PER_LINE-1
//
// state | meaning
// FILL  | priming the window with samples 0..3 of a new line
// RUN   | each accepted sample k+3 produces pair k
// FLUSH | input blocked; last sample re-shifted 3 times for pairs N-3..N-1
module chroma_upsampler #(
   parameter int SAMPLES_PER_LINE = 160,
   parameter int C1 = 21,
   parameter int C3 = 52,
   parameter int C5 = 159
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_even,
   output logic [7:0] out_odd,
   output logic       out_last
);

   typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

   localparam logic [9:0]        LAST_IDX = 10'(SAMPLES_PER_LINE - 1);
   localparam logic signed [19:0] K1 = 20'(C1);
   localparam logic signed [19:0] K3 = 20'(C3);
   localparam logic signed [19:0] K5 = 20'(C5);

   state_t state, state_nxt;
   logic [9:0] cnt;
   logic [1:0] flush_cnt;
   logic [7:0] win [6];
   logic [7:0] win_nxt [6];

   logic out_free, accept;
   logic load_all, shift_in, shift_hold, produce, last_pair;

   logic signed [19:0] s_out, s_mid, s_ctr, acc, acc_sh;
   logic [7:0] odd_nxt;

   assign out_free = !out_valid || out_ready;
   assign in_ready = !rst && (state != FLUSH) && out_free;
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) state <= FILL;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      load_all   = 1'b0;
      shift_in   = 1'b0;
      shift_hold = 1'b0;
      produce    = 1'b0;
      last_pair  = 1'b0;
      case (state)
         FILL: begin
            if (accept) begin
               if (cnt == 10'd0) load_all = 1'b1;
               else              shift_in = 1'b1;
               if (cnt == 10'd3) begin
                  produce   = 1'b1;
                  // a 4-sample line has nothing left to stream after sample 3
                  state_nxt = (cnt == LAST_IDX) ? FLUSH : RUN;
               end
            end
         end
         RUN: begin
            if (accept) begin
               shift_in = 1'b1;
               produce  = 1'b1;
               if (cnt == LAST_IDX) state_nxt = FLUSH;
            end
         end
         FLUSH: begin
            if (out_free) begin
               shift_hold = 1'b1;
               produce    = 1'b1;
               if (flush_cnt == 2'd0) begin
                  last_pair = 1'b1;
                  state_nxt = FILL;
               end
            end
         end
         default: state_nxt = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         flush_cnt <= '0;
      end else begin
         if (accept) cnt <= (cnt == LAST_IDX) ? 10'd0 : cnt + 10'd1;
         if (state_nxt == FLUSH && state != FLUSH) flush_cnt <= 2'd2;
         else if (shift_hold)                      flush_cnt <= flush_cnt - 2'd1;
      end
   end

   // window holds U[k-2..k+3]; the first sample of a line replicates into all taps
   always_comb begin
      win_nxt = win;
      if (load_all) begin
         for (int i = 0; i < 6; i++) win_nxt[i] = in_data;
      end else if (shift_in || shift_hold) begin
         for (int i = 0; i < 5; i++) win_nxt[i] = win[i + 1];
         win_nxt[5] = shift_in ? in_data : win[5];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 6; i++) win[i] <= '0;
      end else begin
         win <= win_nxt;
      end
   end

   // filter runs on the post-shift window so the pair lands with the shift
   always_comb begin
      s_out  = $signed({12'd0, win_nxt[0]} + {12'd0, win_nxt[5]});
      s_mid  = $signed({12'd0, win_nxt[1]} + {12'd0, win_nxt[4]});
      s_ctr  = $signed({12'd0, win_nxt[2]} + {12'd0, win_nxt[3]});
      acc    = K1 * s_out - K3 * s_mid + K5 * s_ctr + 20'sd128;
      acc_sh = acc >>> 8;
   end

`ifdef UPSAMPLE_SAT_EN
   always_comb begin
      if (acc_sh[19])              odd_nxt = 8'd0;
      else if (acc_sh > 20'sd255)  odd_nxt = 8'hff;
      else                         odd_nxt = acc_sh[7:0];
   end
`else
   logic unused_hi;
   assign unused_hi = ^acc_sh[19:8];
   assign odd_nxt   = acc_sh[7:0];
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_even  <= '0;
         out_odd   <= '0;
         out_last  <= 1'b0;
      end else if (produce) begin
         out_valid <= 1'b1;
         out_even  <= win_nxt[2];
         out_odd   <= odd_nxt;
         out_last  <= last_pair;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_chroma_upsampler.sv
module tb_chroma_upsampler;

   localparam int C1 = 21;
   localparam int C3 = 52;
   localparam int C5 = 159;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       in_valid;
   logic [7:0] in_data;
   logic       out_ready;

   logic       a_in_ready, a_out_valid, a_out_last;
   logic [7:0] a_out_even, a_out_odd;
   logic       b_in_ready, b_out_valid, b_out_last;
   logic [7:0] b_out_even, b_out_odd;

   bit         sel;
   logic       in_ready, out_valid, out_last;
   logic [7:0] out_even, out_odd;

   assign in_ready  = sel ? b_in_ready  : a_in_ready;
   assign out_valid = sel ? b_out_valid : a_out_valid;
   assign out_last  = sel ? b_out_last  : a_out_last;
   assign out_even  = sel ? b_out_even  : a_out_even;
   assign out_odd   = sel ? b_out_odd   : a_out_odd;

   chroma_upsampler #(.SAMPLES_PER_LINE(160)) dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
      .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
      .out_even(a_out_even), .out_odd(a_out_odd), .out_last(a_out_last));

   chroma_upsampler #(.SAMPLES_PER_LINE(8)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
      .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready),
      .out_even(b_out_even), .out_odd(b_out_odd), .out_last(b_out_last));

   typedef struct {
      logic [7:0] even;
      logic [7:0] odd;
      logic       last;
   } pair_t;

   pair_t exp_q[$];
   int    in_q[$];
   int    line_buf[1024];
   int    got_even[1024];
   int    got_odd[1024];
   int    got_n, ready_low_cnt, last_cnt;
   int    vectors = 0;
   int    miscompares = 0;
   int    imp_odd[8];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int uc(int n, int i);
      int j;
      j = i;
      if (j < 0) j = 0;
      if (j > n - 1) j = n - 1;
      return line_buf[j];
   endfunction

   function automatic int model_odd(int n, int k);
      int a;
      a = C1 * (uc(n, k - 2) + uc(n, k + 3))
        - C3 * (uc(n, k - 1) + uc(n, k + 2))
        + C5 * (uc(n, k) + uc(n, k + 1)) + 128;
      a = a >>> 8;
`ifdef UPSAMPLE_SAT_EN
      if (a < 0) a = 0;
      else if (a > 255) a = 255;
`else
      a = a & 255;
`endif
      return a;
   endfunction

   task automatic add_line(input int n, input bit with_exp, input int feed_n);
      pair_t p;
      for (int k = 0; k < feed_n; k++) in_q.push_back(line_buf[k]);
      if (with_exp) begin
         for (int k = 0; k < n; k++) begin
            p.even = 8'(line_buf[k]);
            p.odd  = 8'(model_odd(n, k));
            p.last = (k == n - 1);
            exp_q.push_back(p);
         end
      end
   endtask

   task automatic fill_const(input int n, input int v);
      for (int k = 0; k < n; k++) line_buf[k] = v;
   endtask

   task automatic fill_rand(input int n, input bit extremes);
      for (int k = 0; k < n; k++)
         line_buf[k] = extremes ? ($urandom_range(1) ? 255 : 0) : int'($urandom_range(255));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'd0;
      in_q.delete(); exp_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      chk("reset_in_ready", in_ready, 0);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out_even", out_even, 0);
      chk("reset_out_odd", out_odd, 0);
      chk("reset_out_last", out_last, 0);
      rst = 1'b0;
      #1;
      chk("post_reset_in_ready", in_ready, 1);
   endtask

   task automatic run(input int vprob, input int rprob, input int stall_at,
                      input int stall_len, input bit check_en, input int max_cyc);
      int cyc;
      cyc = 0;
      ready_low_cnt = 0; last_cnt = 0; got_n = 0;
      while ((in_q.size() > 0 || (check_en && exp_q.size() > 0)) && cyc < max_cyc) begin
         @(negedge clk);
         in_valid  = (in_q.size() > 0) && ($urandom_range(99) < vprob);
         in_data   = in_valid ? 8'(in_q[0]) : 8'($urandom);
         out_ready = ($urandom_range(99) < rprob);
         if (cyc >= stall_at && cyc < stall_at + stall_len) out_ready = 1'b0;
         #1;
         if (!in_ready) ready_low_cnt++;
         if (check_en && out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
         if (check_en && out_valid) begin
            if (exp_q.size() == 0) chk("spurious_pair", out_valid, 0);
            else begin
               chk("out_even", out_even, exp_q[0].even);
               chk("out_odd", out_odd, exp_q[0].odd);
               chk("out_last", out_last, exp_q[0].last);
            end
         end
         if (in_valid && in_ready) void'(in_q.pop_front());
         if (out_valid && out_ready) begin
            got_even[got_n] = out_even;
            got_odd[got_n]  = out_odd;
            if (got_n < 1023) got_n++;
            if (out_last) last_cnt++;
            if (check_en && exp_q.size() > 0) void'(exp_q.pop_front());
         end
         @(posedge clk);
         cyc++;
      end
      if (check_en) chk("drained", in_q.size() + exp_q.size(), 0);
      else          chk("fed", in_q.size(), 0);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0; sel = 1'b0;
      imp_odd[0] = 0; imp_odd[1] = 0; imp_odd[2] = 21; imp_odd[4] = 158;
      imp_odd[5] = 158; imp_odd[7] = 21;
`ifdef UPSAMPLE_SAT_EN
      imp_odd[3] = 0;   imp_odd[6] = 0;
`else
      imp_odd[3] = 204; imp_odd[6] = 204;
`endif

      // constant line, full rate
      sel = 1'b0;
      do_reset();
      fill_const(160, 100);
      add_line(160, 1'b1, 160);
      run(100, 100, 0, 0, 1'b1, 2000);
      chk("const_pairs", got_n, 160);
      chk("const_last_cnt", last_cnt, 1);
      chk("const_odd_0", got_odd[0], 100);
      chk("const_odd_159", got_odd[159], 100);

      // back-to-back lines, continuous input
      do_reset();
      fill_rand(160, 1'b0); add_line(160, 1'b1, 160);
      fill_rand(160, 1'b0); add_line(160, 1'b1, 160);
      run(100, 100, 0, 0, 1'b1, 2000);
      chk("b2b_ready_low", ready_low_cnt, 6);
      chk("b2b_last_cnt", last_cnt, 2);
      chk("b2b_pairs", got_n, 320);

      // mid-line 5-cycle stall
      do_reset();
      fill_rand(160, 1'b0); add_line(160, 1'b1, 160);
      run(100, 100, 40, 5, 1'b1, 2000);
      chk("stall_pairs", got_n, 160);

      // random traffic both sides
      do_reset();
      for (int l = 0; l < 3; l++) begin
         fill_rand(160, 1'b0); add_line(160, 1'b1, 160);
      end
      run(70, 60, 0, 0, 1'b1, 5000);
      chk("rand_last_cnt", last_cnt, 3);

      // impulse on the short-line instance
      sel = 1'b1;
      do_reset();
      fill_const(8, 0); line_buf[5] = 255;
      add_line(8, 1'b1, 8);
      run(100, 100, 0, 0, 1'b1, 200);
      for (int k = 0; k < 8; k++) chk($sformatf("impulse_odd_%0d", k), got_odd[k], imp_odd[k]);
      chk("impulse_even_5", got_even[5], 255);

      // extreme-valued short lines under random flow
      for (int l = 0; l < 6; l++) begin
         fill_rand(8, 1'b1); add_line(8, 1'b1, 8);
      end
      run(80, 50, 0, 0, 1'b1, 1000);
      chk("short_last_cnt", last_cnt, 6);

      // reset after 50 samples, then a clean constant line
      sel = 1'b0;
      do_reset();
      fill_rand(160, 1'b0); add_line(160, 1'b0, 50);
      run(100, 100, 0, 0, 1'b0, 500);
      do_reset();
      fill_const(160, 100); add_line(160, 1'b1, 160);
      run(100, 100, 0, 0, 1'b1, 2000);
      chk("rst_mid_pairs", got_n, 160);
      chk("rst_mid_last_cnt", last_cnt, 1);
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) begin
         @(negedge clk); #1;
         chk("idle_out_valid", out_valid, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
